// File: rtl/uart_tx_unit_pkg.sv
// Shared MiniUart transmitter definitions: FSM state encoding, default bit timing
// and the parity helper used when UART_TX_PARITY_EN is defined.
package uart_tx_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int TICKS_PER_BIT_DEF = 8;

  // Even parity: the parity bit makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_unit.sv
// MiniUart transmitting unit: THR + TSR double buffer shifting start/8 data/stop onto txd.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx_unit
  import uart_tx_unit_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tx,
  input  logic [7:0] d_in,
  input  logic       load,
  output logic       ts,
  output logic       busy,
  output logic       txd,
  output logic       IRQ,
  output tx_state_t  state_dbg
);

  // Handshake: a write is accepted on any clk edge where load && ts; ts then drops
  // until the FSM moves THR into TSR. Writes while ts=0 are silently discarded.

  localparam int CNT_W = $clog2(TICKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICKS_PER_BIT - 1);

  tx_state_t        state;
  logic [7:0]       thr;
  logic [7:0]       tsr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bits;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  assign IRQ       = ts;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      thr   <= '0;
      tsr   <= '0;
      cnt   <= '0;
      bits  <= '0;
      ts    <= 1'b1;
      txd   <= 1'b1;
      busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      // A transfer only fires with ts=0, a write only with ts=1: they never collide.
      if (load && ts) begin
        thr <= d_in;
        ts  <= 1'b0;
      end
      if (en_tx) begin
        unique case (state)
          ST_IDLE: begin
            if (!ts) begin
              tsr   <= thr;
              ts    <= 1'b1;
              txd   <= 1'b0;
              cnt   <= CNT_RELOAD;
              bits  <= 3'd7;
              busy  <= 1'b1;
              state <= ST_START;
`ifdef UART_TX_PARITY_EN
              par   <= even_parity(thr);
`endif
            end
          end
          ST_START: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              cnt   <= CNT_RELOAD;
              txd   <= tsr[0];
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              cnt  <= CNT_RELOAD;
              tsr  <= tsr >> 1;
              bits <= bits - 3'd1;
              if (bits == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                txd   <= par;
                state <= ST_PARITY;
`else
                txd   <= 1'b1;
                state <= ST_STOP;
`endif
              end else begin
                txd <= tsr[1];
              end
            end
          end
          ST_PARITY: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              cnt   <= CNT_RELOAD;
              txd   <= 1'b1;
              state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (!ts) begin
              // Pending byte: chain straight into the next start bit with no idle gap.
              tsr   <= thr;
              ts    <= 1'b1;
              txd   <= 1'b0;
              cnt   <= CNT_RELOAD;
              bits  <= 3'd7;
              state <= ST_START;
`ifdef UART_TX_PARITY_EN
              par   <= even_parity(thr);
`endif
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            txd   <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: frame-level model, tick-based serial receiver,
// and directed scenarios (define UART_TX_PARITY_EN to include the parity scenario).
`timescale 1ns/1ps
module tb_uart_tx_unit;
  import uart_tx_unit_pkg::*;

  localparam int T = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_tx = 1'b1;
  logic       load = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       ts, busy, txd, irq;
  tx_state_t  state_dbg;

  always #5 clk = ~clk;

  uart_tx_unit #(.TICKS_PER_BIT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_tx     (en_tx),
    .d_in      (d_in),
    .load      (load),
    .ts        (ts),
    .busy      (busy),
    .txd       (txd),
    .IRQ       (irq),
    .state_dbg (state_dbg)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [7:0] exp_q[$];
  logic [0:0] par_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // A frame is a list of NBITS serial bits; the expected txd is simply the bit
  // selected by the number of en_tx ticks elapsed since the frame started.
  logic             m_ts, m_active;
  logic [7:0]       m_thr;
  logic [NBITS-1:0] m_frame;
  int               m_tick;
  bit               m_load_ok, m_start;

  function automatic logic [NBITS-1:0] build_frame(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f        = '1;
    f[0]     = 1'b0;
    f[8:1]   = b;
`ifdef UART_TX_PARITY_EN
    f[9]     = ^b;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ts = 1'b1; m_active = 1'b0; m_thr = 8'h00; m_tick = 0; m_frame = '1;
    end else begin
      m_load_ok = load && m_ts;
      m_start   = 1'b0;
      if (en_tx) begin
        if (m_active) begin
          m_tick++;
          if (m_tick == NBITS * T) begin
            m_active = 1'b0;
            m_start  = !m_ts;
          end
        end else begin
          m_start = !m_ts;
        end
      end
      if (m_start) begin
        m_frame = build_frame(m_thr); m_ts = 1'b1; m_tick = 0; m_active = 1'b1;
      end
      if (m_load_ok) begin
        m_thr = d_in; m_ts = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd",  txd,  m_active ? m_frame[m_tick / T] : 1'b1);
      check("ts",   ts,   m_ts);
      check("irq",  irq,  m_ts);
      check("busy", busy, m_active);
    end
  end

  // ---------------- tick-based serial receiver / scoreboard ----------------
  // Inputs change just after posedge, so at negedge en_tx is the value the next edge uses.
  bit         r_on = 1'b0;
  int         r_tick, r_k;
  logic [7:0] r_byte;
  logic       r_par;

  always @(negedge clk) begin
    if (rst || !chk_en) begin
      r_on = 1'b0;
    end else if (en_tx) begin
      if (!r_on && txd === 1'b0) begin
        r_on = 1'b1; r_tick = 0; r_byte = 8'h00; r_par = 1'b0;
      end
      if (r_on) begin
        if (r_tick % T == T / 2) begin
          r_k = r_tick / T;
          if (r_k == 0) begin
            check("rx_start", txd, 1'b0);
          end else if (r_k <= 8) begin
            r_byte[r_k-1] = txd;
`ifdef UART_TX_PARITY_EN
          end else if (r_k == 9) begin
            r_par = txd;
`endif
          end else begin
            check("rx_stop", txd, 1'b1);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rx_byte: got unexpected frame %0h expected none", r_byte);
            end else begin
              check("rx_byte", r_byte, exp_q.pop_front());
            end
`ifdef UART_TX_PARITY_EN
            if (par_q.size() != 0) check("rx_parity", r_par, par_q.pop_front());
`endif
            r_on = 1'b0;
          end
        end
        r_tick++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [7:0] b);
    @(posedge clk); #1;
    load = 1'b1; d_in = b;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_txd(input logic v, input int budget, input string name);
    int n = 0;
    while (txd !== v && n < budget) begin @(negedge clk); n++; end
    check(name, txd, v);
  endtask

  task automatic measure_busy(output int len);
    int n = 0;
    len = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("busy_rise", busy, 1'b1);
    while (busy === 1'b1 && len < 2000) begin @(negedge clk); len++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && ts === 1'b1) && n < 500) begin @(negedge clk); n++; end
    check("idle_timeout", {busy, ts}, 2'b01);
    repeat (5) @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  int len, run;

  initial begin
    // 1: reset held for 3 clocks
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_ts", ts, 1'b1);
    check("rst_irq", irq, 1'b1);
    check("rst_busy", busy, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // 2: single frame 0x55, 80 clocks busy
    exp_q.push_back(8'h55);
    par_q.push_back(1'b0);
    do_load(8'h55);
    measure_busy(len);
    check("frame_len_55", len, NBITS * T);
    wait_idle();

    // 3: back-to-back A5 / 3C, extra write while THR is full is dropped
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    par_q.push_back(1'b0);
    par_q.push_back(1'b0);
    fork
      begin
        measure_busy(len);
        check("b2b_len", len, 2 * NBITS * T);
      end
      begin
        do_load(8'hA5);
        @(negedge clk);
        while (ts !== 1'b1) @(negedge clk);
        do_load(8'h3C);
        do_load(8'h77);
      end
    join
    wait_idle();

    // 4: 0x11 then 0x22 while ts=0 (ticks held off so no transfer can free THR)
    exp_q.push_back(8'h11);
    par_q.push_back(1'b0);
    @(posedge clk); #1 en_tx = 1'b0;
    do_load(8'h11);
    do_load(8'h22);
    @(negedge clk);
    check("hold_ts", ts, 1'b0);
    check("hold_busy", busy, 1'b0);
    @(posedge clk); #1 en_tx = 1'b1;
    measure_busy(len);
    check("frame_len_11", len, NBITS * T);
    wait_idle();

    // 5: stall en_tx for 20 clocks inside data bit 3 of 0x08 (the only 1 bit)
    exp_q.push_back(8'h08);
    par_q.push_back(1'b1);
    fork
      begin
        do_load(8'h08);
        wait_txd(1'b0, 50, "stall_start");
        repeat (34) @(posedge clk);
        #1 en_tx = 1'b0;
        repeat (20) @(posedge clk);
        #1 en_tx = 1'b1;
      end
      begin
        wait_txd(1'b0, 50, "run_start");
        wait_txd(1'b1, 200, "run_high");
        run = 0;
        while (txd === 1'b1 && run < 200) begin @(negedge clk); run++; end
        check("bit3_len", run, 28);
      end
    join
    wait_idle();

    // 6: reset during data bit 4 of 0xF0, then a clean 0x0F frame
    do_load(8'hF0);
    wait_txd(1'b0, 50, "rst_frame_start");
    repeat (8 + 32 + 3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_txd", txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ts", ts, 1'b1);
    exp_q.push_back(8'h0F);
    par_q.push_back(1'b0);
    do_load(8'h0F);
    measure_busy(len);
    check("frame_len_0f", len, NBITS * T);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // 7: parity frames, 88 clocks each
    exp_q.push_back(8'h07);
    par_q.push_back(1'b1);
    do_load(8'h07);
    measure_busy(len);
    check("par_len_07", len, 88);
    wait_idle();
    exp_q.push_back(8'h03);
    par_q.push_back(1'b0);
    do_load(8'h03);
    measure_busy(len);
    check("par_len_03", len, 88);
    wait_idle();
`endif

    repeat (20) @(posedge clk);
    check("rx_all_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
